// File: rtl/exe_mem_stage.sv
// exe_mem_stage: EXE->MEM pipeline register with a 2-entry skid buffer, flush and a saturating stall counter
module exe_mem_stage #(
  parameter int DATA_W      = 32,
  parameter int RN_W        = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_result,
  input  logic [DATA_W-1:0]      in_rb,
  input  logic                   in_wmem,
  input  logic                   in_m2reg,
  input  logic                   in_wreg,
  input  logic [RN_W-1:0]        in_rn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_result,
  output logic [DATA_W-1:0]      out_rb,
  output logic                   out_wmem,
  output logic                   out_m2reg,
  output logic                   out_wreg,
  output logic [RN_W-1:0]        out_rn,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  localparam int PW = 2 * DATA_W + 3 + RN_W;
  logic          m_v, s_v, in_fire;
  logic [PW-1:0] m_p, s_p, in_p;
  assign in_p      = {in_result, in_rb, in_wmem, in_m2reg, in_wreg, in_rn};
  assign {out_result, out_rb, out_wmem, out_m2reg, out_wreg, out_rn} = m_p;
  assign out_valid = m_v;
  assign in_ready  = !s_v;
  assign in_fire   = in_valid && !s_v;
  // Empty entries always carry a zero payload so a bubble never writes memory or registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      m_v       <= 1'b0;
      s_v       <= 1'b0;
      m_p       <= '0;
      s_p       <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m_p <= '0;
      s_p <= '0;
    end else begin
      if (m_v && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      // Main entry frees up: refill from skid first, else from input, else bubble.
      if (!m_v || out_ready) begin
        m_v <= s_v || in_fire;
        m_p <= s_v ? s_p : in_fire ? in_p : '0;
        s_v <= 1'b0;
        s_p <= '0;
      end else if (in_fire) begin
        s_v <= 1'b1;
        s_p <= in_p;
      end
    end
  end
endmodule

// File: tb/tb_exe_mem_stage.sv
// tb_exe_mem_stage: scoreboard bench for exe_mem_stage against a 2-deep FIFO reference model
module tb_exe_mem_stage;
  typedef struct packed {
    logic [31:0] result;
    logic [31:0] rb;
    logic        wmem;
    logic        m2reg;
    logic        wreg;
    logic [4:0]  rn;
  } pl_t;

  logic        clk = 0, clr = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_result = 0, in_rb = 0;
  logic        in_wmem = 0, in_m2reg = 0, in_wreg = 0;
  logic [4:0]  in_rn = 0;
  logic        in_ready, out_valid, out_wmem, out_m2reg, out_wreg;
  logic [31:0] out_result, out_rb;
  logic [4:0]  out_rn;
  logic [15:0] stall_cnt;
  logic        b_in_ready, b_out_valid, b_out_wmem, b_out_m2reg, b_out_wreg;
  logic [31:0] b_out_result, b_out_rb;
  logic [4:0]  b_out_rn;
  logic [2:0]  b_stall_cnt;

  pl_t sb[$];
  int  vectors = 0, miscompares = 0, held = 0, stalls = 0;
  bit  mon_en = 0;

  always #5 clk = ~clk;

  exe_mem_stage dut (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rb(in_rb), .in_wmem(in_wmem), .in_m2reg(in_m2reg),
    .in_wreg(in_wreg), .in_rn(in_rn), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rb(out_rb), .out_wmem(out_wmem), .out_m2reg(out_m2reg),
    .out_wreg(out_wreg), .out_rn(out_rn), .stall_cnt(stall_cnt)
  );

  exe_mem_stage #(.STALL_CNT_W(3)) dut_sat (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_result(in_result), .in_rb(in_rb), .in_wmem(in_wmem), .in_m2reg(in_m2reg),
    .in_wreg(in_wreg), .in_rn(in_rn), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_result(b_out_result), .out_rb(b_out_rb), .out_wmem(b_out_wmem), .out_m2reg(b_out_m2reg),
    .out_wreg(b_out_wreg), .out_rn(b_out_rn), .stall_cnt(b_stall_cnt)
  );

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares handshake, stall counters and the head-of-queue payload every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      pl_t a, b;
      a = {out_result, out_rb, out_wmem, out_m2reg, out_wreg, out_rn};
      b = {b_out_result, b_out_rb, b_out_wmem, b_out_m2reg, b_out_wreg, b_out_rn};
      chk("in_ready", in_ready, held < 2);
      chk("out_valid", out_valid, held > 0);
      chk("b_in_ready", b_in_ready, held < 2);
      chk("b_out_valid", b_out_valid, held > 0);
      chk("stall_cnt", stall_cnt, stalls > 65535 ? 65535 : stalls);
      chk("stall_cnt_sat3", b_stall_cnt, stalls > 7 ? 7 : stalls);
      if (!out_valid) chk("bubble_zero", a, 0);
      else if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underflow: got out_valid=1 expected no entry held");
      end else begin
        chk("payload", a, sb[0]);
        chk("b_payload", b, sb[0]);
        if (out_ready && !flush && !clr) void'(sb.pop_front());
      end
    end
  end

  function automatic pl_t mk(logic [31:0] r);
    pl_t p;
    p.result = r;
    p.rb     = $urandom;
    p.wmem   = 1'($urandom);
    p.m2reg  = 1'($urandom);
    p.wreg   = 1'($urandom);
    p.rn     = 5'($urandom);
    return p;
  endfunction

  // Drive one cycle, then advance the reference FIFO model on the edge.
  task automatic step(bit v, bit r, bit f, bit c, pl_t p);
    bit fi, fo;
    {in_result, in_rb, in_wmem, in_m2reg, in_wreg, in_rn} = p;
    in_valid = v; out_ready = r; flush = f; clr = c;
    @(posedge clk);
    if (c) begin
      held = 0; stalls = 0; sb.delete();
    end else if (f) begin
      held = 0; sb.delete();
    end else begin
      if (held > 0 && !r) stalls++;
      fi = v && held < 2;
      fo = held > 0 && r;
      held = held - int'(fo) + int'(fi);
      if (fi) sb.push_back(p);
    end
    mon_en = 1;
    #1;
  endtask

  initial begin
    pl_t z, pt;
    z = '0;
    step(1, 0, 0, 1, mk(32'hDEADBEEF));
    step(1, 0, 0, 1, mk(32'hDEADBEEF));
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 0, mk(i));
    step(0, 1, 0, 0, z);
    step(0, 1, 0, 0, z);
    step(1, 0, 0, 0, mk(10));
    step(1, 0, 0, 0, mk(20));
    pt = mk(30);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, pt);
    step(1, 1, 0, 0, pt);
    step(1, 1, 0, 0, pt);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, z);
    step(1, 0, 0, 0, mk(32'hA));
    step(1, 0, 0, 0, mk(32'hB));
    step(1, 0, 1, 0, mk(32'hC));
    step(0, 1, 0, 0, z);
    step(0, 1, 0, 0, z);
    step(1, 0, 0, 0, mk(32'h55));
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, z);
    step(0, 1, 0, 0, z);
    step(0, 1, 0, 0, z);
    pt = '{result: 32'h0, rb: 32'h12345678, wmem: 1'b1, m2reg: 1'b0, wreg: 1'b0, rn: 5'd31};
    step(1, 1, 0, 0, pt);
    step(0, 1, 0, 0, z);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(39) == 0,
           $urandom_range(499) == 0, mk($urandom));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, z);
    chk("drained", sb.size(), held);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/exe_mem_stage.md
Name: exe_mem_stage

Overview:
Parametrised EXE->MEM pipeline stage register, successor to the fixed-width EXE/MEM latch. Adds a valid/ready handshake with a 2-entry skid buffer (registered in_ready), a flush that inserts a bubble, and a saturating back-pressure counter. Sits between the ALU stage and the data-memory stage; width of result/operand and register-number fields is configurable.

Parameters:
DATA_W, 32, width of result and rb payload fields
RN_W, 5, width of destination register number
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clk  input  1  clock, all state updates on rising edge
clr  input  1  synchronous active-high reset
flush  input  1  synchronous squash of all held entries (branch/exception)
in_valid  input  1  EXE stage presents a valid instruction
in_ready  output  1  stage can accept this cycle (registered)
in_result  input  DATA_W  ALU result
in_rb  input  DATA_W  store data (operand b)
in_wmem  input  1  write-memory control
in_m2reg  input  1  select memory data for writeback
in_wreg  input  1  write-register control
in_rn  input  RN_W  destination register number
out_valid  output  1  MEM stage entry valid
out_ready  input  1  MEM stage accepts this cycle
out_result  output  DATA_W  held result
out_rb  output  DATA_W  held store data
out_wmem  output  1  held wmem
out_m2reg  output  1  held m2reg
out_wreg  output  1  held wreg
out_rn  output  RN_W  held register number
stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main entry M (drives all out_*), skid entry S. Each = valid bit + payload {result, rb, wmem, m2reg, wreg, rn}.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- out_valid = M.v; in_ready = !S.v, both straight from flops.
- Invariant: an invalid entry holds all-zero payload -> out_wmem/out_wreg/out_m2reg are 0 whenever out_valid=0 (bubble is safe even if downstream ignores valid).
- Reset (clr=1, highest priority): M, S valid and payload all 0; stall_cnt=0; in_ready=1 after the edge.
- Flush (clr=0, flush=1): M and S cleared to invalid/zero; input in that cycle dropped even if in_valid=1; out_ready ignored; stall_cnt unchanged.
- Normal (clr=0, flush=0), states by (M.v,S.v):
  EMPTY (0,0): in_fire -> M<=in, ONE; else stay.
  ONE (1,0): out_fire & in_fire -> M<=in, ONE. out_fire only -> M cleared, EMPTY. in_fire & !out_ready -> S<=in, FULL. neither -> hold.
  FULL (1,1): in_ready=0. out_fire -> M<=S, S cleared, ONE. else hold.
- (0,1) unreachable; if forced, next normal edge moves S into M.
- Latency: in_fire at edge N -> on outputs after edge N (1 cycle). Sustained throughput 1 per cycle with out_ready=1.
- Ordering strictly FIFO; no entry lost or duplicated under any out_ready pattern.
- Payload bits pass unmodified; no arithmetic on data.
- stall_cnt: +1 each edge where out_valid=1 & out_ready=0 & flush=0; holds at 2^STALL_CNT_W-1; only clr clears it.

Test Plan:
- Reset: clr=1 two cycles with in_valid=1, in_result=32'hDEADBEEF -> out_valid=0, all out_* 0, stall_cnt=0, in_ready=1.
- Streaming: out_ready=1, in_valid=1 with result 1,2,3,4 on consecutive cycles -> out_result 1,2,3,4 one cycle later each, in_ready stays 1.
- Back-pressure: deliver A=10, B=20 with out_ready=0 -> after B, in_ready=0, out_result=10; C=30 held at input; raise out_ready -> out sequence 10,20,30, none lost; stall_cnt equals stalled-cycle count.
- Flush in FULL: entries A,B held, flush=1 with in_valid=1 (C) -> next cycle out_valid=0, out_wmem=0, out_wreg=0, in_ready=1; C never appears.
- Saturation: STALL_CNT_W=3, out_valid=1, out_ready=0 for 10 cycles -> stall_cnt reaches 7 and holds.
- Control passthrough: in_wmem=1, in_m2reg=0, in_wreg=0, in_rn=5'd31, in_rb=32'h12345678 -> identical values on out_* one cycle later.
